// File: rtl/psk_acq_sequencer.sv
// psk_acq_sequencer: frequency-sweep acquisition controller for the PSK correlator datapath.
// Ports:
//   clk, rst_in        clock and synchronous active-high reset
//   start              begin a sweep (honoured only in IDLE, LOCK and FAIL)
//   i_value, q_value   signed correlator sums, sampled on the dump_stb cycle
//   corr_rst           one-cycle correlator clear at the start of each window
//   dump_stb           one-cycle strobe marking the end of an integration window
//   fcw, bin_idx       NCO frequency control word and current bin index
//   busy, locked, fail sweep in progress / locked to best bin / no bin above threshold
//   best_fcw, best_mag strongest bin seen so far and its accumulated magnitude
module psk_acq_sequencer #(
    parameter int FCW_W       = 13,
    parameter int FCW_START   = 512,
    parameter int FCW_STEP    = 16,
    parameter int N_BINS      = 16,
    parameter int INT_LEN     = 256,
    parameter int DWELLS      = 4,
    parameter int LOCK_THRESH = 64
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       start,
    input  logic [7:0]                 i_value,
    input  logic [7:0]                 q_value,
    output logic                       corr_rst,
    output logic                       dump_stb,
    output logic [FCW_W-1:0]           fcw,
    output logic [7:0]                 bin_idx,
    output logic                       busy,
    output logic                       locked,
    output logic                       fail,
    output logic [FCW_W-1:0]           best_fcw,
    output logic [8+$clog2(DWELLS):0]  best_mag
);
    localparam int ACC_W = 9 + $clog2(DWELLS);
    localparam int DW_W  = DWELLS > 1 ? $clog2(DWELLS) : 1;
    localparam int CNT_W = $clog2(INT_LEN);

    typedef enum logic [3:0] {IDLE, CLEAR, INTEG, DUMP, EVAL, NEXT, DECIDE, LOCK, FAIL} state_t;

    state_t             state, state_n;
    logic [FCW_W-1:0]   fcw_n, best_fcw_n;
    logic [7:0]         bin_n;
    logic [ACC_W-1:0]   acc, acc_n, best_mag_n;
    logic [DW_W-1:0]    dwell, dwell_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [8:0]         abs_i, abs_q, mag;

    // Sign-extend to 9 bits before negating so |-128| = 128 is representable.
    assign abs_i = i_value[7] ? 9'd0 - {1'b1, i_value} : {1'b0, i_value};
    assign abs_q = q_value[7] ? 9'd0 - {1'b1, q_value} : {1'b0, q_value};
    assign mag   = abs_i + abs_q;

    always_comb begin
        state_n    = state;
        fcw_n      = fcw;
        bin_n      = bin_idx;
        best_fcw_n = best_fcw;
        best_mag_n = best_mag;
        acc_n      = acc;
        dwell_n    = dwell;
        cnt_n      = cnt;
        case (state)
            IDLE, LOCK, FAIL: if (start) begin
                state_n    = CLEAR;
                fcw_n      = FCW_W'(FCW_START);
                bin_n      = '0;
                best_fcw_n = FCW_W'(FCW_START);
                best_mag_n = '0;
                acc_n      = '0;
                dwell_n    = '0;
            end
            CLEAR: begin
                cnt_n   = '0;
                state_n = INTEG;
            end
            INTEG: begin
                if (cnt == CNT_W'(INT_LEN - 1)) state_n = DUMP;
                else cnt_n = cnt + 1'b1;
            end
            DUMP: begin
                acc_n = acc + ACC_W'(mag);
                if (dwell == DW_W'(DWELLS - 1)) state_n = EVAL;
                else begin
                    dwell_n = dwell + 1'b1;
                    state_n = CLEAR;
                end
            end
            EVAL: begin
                // Strict compare: on a tie the earlier (lower) bin is kept.
                if (acc > best_mag) begin
                    best_mag_n = acc;
                    best_fcw_n = fcw;
                end
                acc_n   = '0;
                dwell_n = '0;
                state_n = bin_idx == 8'(N_BINS - 1) ? DECIDE : NEXT;
            end
            NEXT: begin
                fcw_n   = fcw + FCW_W'(FCW_STEP);
                bin_n   = bin_idx + 8'd1;
                state_n = CLEAR;
            end
            DECIDE: begin
                if (32'(best_mag) >= 32'(LOCK_THRESH * DWELLS)) begin
                    fcw_n   = best_fcw;
                    state_n = LOCK;
                end else begin
                    fcw_n   = FCW_W'(FCW_START);
                    state_n = FAIL;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state    <= IDLE;
            fcw      <= FCW_W'(FCW_START);
            bin_idx  <= '0;
            best_fcw <= FCW_W'(FCW_START);
            best_mag <= '0;
            acc      <= '0;
            dwell    <= '0;
            cnt      <= '0;
            corr_rst <= 1'b0;
            dump_stb <= 1'b0;
            busy     <= 1'b0;
            locked   <= 1'b0;
            fail     <= 1'b0;
        end else begin
            state    <= state_n;
            fcw      <= fcw_n;
            bin_idx  <= bin_n;
            best_fcw <= best_fcw_n;
            best_mag <= best_mag_n;
            acc      <= acc_n;
            dwell    <= dwell_n;
            cnt      <= cnt_n;
            corr_rst <= state_n == CLEAR;
            dump_stb <= state_n == DUMP;
            busy     <= !(state_n inside {IDLE, LOCK, FAIL});
            locked   <= state_n == LOCK;
            fail     <= state_n == FAIL;
        end
    end
endmodule

// File: tb/tb_psk_acq_sequencer.sv
// tb_psk_acq_sequencer: directed self-checking bench for psk_acq_sequencer.
module tb_psk_acq_sequencer;
    logic        clk = 1'b0;
    logic        rst_in, start, start2;
    logic [7:0]  i_value, q_value, i2, q2;
    logic        corr_rst, dump_stb, busy, locked, fail;
    logic        corr_rst2, dump_stb2, busy2, locked2, fail2;
    logic [12:0] fcw, best_fcw, fcw2, best_fcw2;
    logic [7:0]  bin_idx, bin_idx2;
    logic [10:0] best_mag, best_mag2;
    logic [12:0] pk_fcw;
    logic [7:0]  pk_i, pk_q, bg_i, bg_q, pk2_i, pk2_q;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Signal source: one bin (by fcw) returns the peak pair, all others the background pair.
    assign i_value = fcw == pk_fcw ? pk_i : bg_i;
    assign q_value = fcw == pk_fcw ? pk_q : bg_q;
    assign i2      = fcw2 == 13'd40 ? pk2_i : 8'd0;
    assign q2      = fcw2 == 13'd40 ? pk2_q : 8'd0;

    psk_acq_sequencer dut (
        .clk(clk), .rst_in(rst_in), .start(start), .i_value(i_value), .q_value(q_value),
        .corr_rst(corr_rst), .dump_stb(dump_stb), .fcw(fcw), .bin_idx(bin_idx),
        .busy(busy), .locked(locked), .fail(fail), .best_fcw(best_fcw), .best_mag(best_mag)
    );

    psk_acq_sequencer #(.FCW_START(8184), .INT_LEN(8)) dut2 (
        .clk(clk), .rst_in(rst_in), .start(start2), .i_value(i2), .q_value(q2),
        .corr_rst(corr_rst2), .dump_stb(dump_stb2), .fcw(fcw2), .bin_idx(bin_idx2),
        .busy(busy2), .locked(locked2), .fail(fail2), .best_fcw(best_fcw2), .best_mag(best_mag2)
    );

    typedef struct {
        logic [12:0] pk_fcw;
        logic [7:0]  pk_i, pk_q, bg_i, bg_q;
        logic        e_lock, e_fail;
        logic [12:0] e_best_fcw;
        logic [10:0] e_best_mag;
        logic [12:0] e_fcw;
    } vec_t;

    vec_t tv[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch a sweep on dut and follow it to LOCK/FAIL, counting pulses and
    // checking bin_idx/fcw at every window start.
    task automatic sweep(output int lat, output int ncr, output int nds, output int seq_err);
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = 1; ncr = 0; nds = 0; seq_err = 0;
        while (!(locked || fail) && lat < 20000) begin
            if (corr_rst) begin
                if (bin_idx != 8'(ncr / 4) || fcw != 13'(512 + 16 * (ncr / 4))) seq_err++;
                ncr++;
            end
            if (dump_stb) nds++;
            tick;
            lat++;
        end
    endtask

    initial begin
        int lat, ncr, nds, seq_err, pulses;
        logic pulsed, done, seen8;
        tv[0] = '{13'd592, 8'd10, 8'd10, 8'd10, 8'd10, 1'b0, 1'b1, 13'd512, 11'd80, 13'd512};
        tv[1] = '{13'd544, 8'd64, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 13'd544, 11'd256, 13'd544};
        tv[2] = '{13'd592, 8'd100, 8'hCE, 8'd3, 8'hFE, 1'b1, 1'b0, 13'd592, 11'd600, 13'd592};
        rst_in = 1'b1; start = 1'b0; start2 = 1'b0;
        pk_fcw = 13'd0; pk_i = 8'd0; pk_q = 8'd0; bg_i = 8'd0; bg_q = 8'd0;
        pk2_i = 8'd0; pk2_q = 8'd0;
        repeat (3) tick;
        chk("rst_fcw", 32'(fcw), 32'd512);
        chk("rst_bin", 32'(bin_idx), 32'd0);
        chk("rst_best_fcw", 32'(best_fcw), 32'd512);
        chk("rst_best_mag", 32'(best_mag), 32'd0);
        chk("rst_flags", {27'd0, corr_rst, dump_stb, busy, locked, fail}, 32'd0);
        rst_in = 1'b0;
        pulses = 0;
        for (int c = 0; c < 1000; c++) begin
            tick;
            if (corr_rst || dump_stb || busy || locked || fail || fcw != 13'd512) pulses++;
        end
        chk("idle_quiet", 32'(pulses), 32'd0);

        for (int k = 0; k < 3; k++) begin
            pk_fcw = tv[k].pk_fcw; pk_i = tv[k].pk_i; pk_q = tv[k].pk_q;
            bg_i = tv[k].bg_i; bg_q = tv[k].bg_q;
            sweep(lat, ncr, nds, seq_err);
            chk($sformatf("v%0d_locked", k), 32'(locked), 32'(tv[k].e_lock));
            chk($sformatf("v%0d_fail", k), 32'(fail), 32'(tv[k].e_fail));
            chk($sformatf("v%0d_best_fcw", k), 32'(best_fcw), 32'(tv[k].e_best_fcw));
            chk($sformatf("v%0d_best_mag", k), 32'(best_mag), 32'(tv[k].e_best_mag));
            chk($sformatf("v%0d_fcw", k), 32'(fcw), 32'(tv[k].e_fcw));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
            chk($sformatf("v%0d_latency", k), 32'(lat), 32'(16 * (4 * 258 + 2) + 1));
            chk($sformatf("v%0d_corr_rst_cnt", k), 32'(ncr), 32'd64);
            chk($sformatf("v%0d_dump_cnt", k), 32'(nds), 32'd64);
            chk($sformatf("v%0d_bin_seq", k), 32'(seq_err), 32'd0);
        end

        // Relaunch from LOCK, ignore start while busy, then reset inside bin 9.
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("relaunch_corr_rst", 32'(corr_rst), 32'd1);
        chk("relaunch_fcw", 32'(fcw), 32'd512);
        chk("relaunch_locked", 32'(locked), 32'd0);
        chk("relaunch_busy", 32'(busy), 32'd1);
        chk("relaunch_best_mag", 32'(best_mag), 32'd0);
        ncr = 0; seq_err = 0; pulsed = 1'b0; done = 1'b0;
        for (int c = 0; c < 12000 && !done; c++) begin
            start = 1'b0;
            if (!busy) seq_err++;
            if (corr_rst) begin
                if (bin_idx != 8'(ncr / 4) || fcw != 13'(512 + 16 * (ncr / 4))) seq_err++;
                ncr++;
            end
            if (bin_idx == 8'd7 && !corr_rst && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (bin_idx == 8'd9 && !corr_rst) begin
                rst_in = 1'b1;
                done = 1'b1;
            end
            tick;
        end
        rst_in = 1'b0; start = 1'b0;
        chk("midrst_reached", 32'(done), 32'd1);
        chk("busy_start_seq", 32'(seq_err), 32'd0);
        chk("busy_start_windows", 32'(ncr), 32'd37);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_bin", 32'(bin_idx), 32'd0);
        chk("midrst_best_mag", 32'(best_mag), 32'd0);
        chk("midrst_best_fcw", 32'(best_fcw), 32'd512);
        chk("midrst_fcw", 32'(fcw), 32'd512);
        chk("midrst_flags", {29'd0, corr_rst, locked, fail}, 32'd0);

        // Wrapped fcw sweep on the short-window instance: full-scale peak, then just below threshold.
        for (int k = 0; k < 2; k++) begin
            pk2_i = k == 0 ? 8'h80 : 8'hC1;
            pk2_q = k == 0 ? 8'h80 : 8'h00;
            start2 = 1'b1;
            tick;
            start2 = 1'b0;
            lat = 1; seen8 = 1'b0;
            while (!(locked2 || fail2) && lat < 2000) begin
                if (bin_idx2 == 8'd1 && corr_rst2 && fcw2 == 13'd8) seen8 = 1'b1;
                tick;
                lat++;
            end
            chk($sformatf("wrap%0d_latency", k), 32'(lat), 32'd673);
            chk($sformatf("wrap%0d_bin1_fcw8", k), 32'(seen8), 32'd1);
            chk($sformatf("wrap%0d_locked", k), 32'(locked2), k == 0 ? 32'd1 : 32'd0);
            chk($sformatf("wrap%0d_fail", k), 32'(fail2), k == 0 ? 32'd0 : 32'd1);
            chk($sformatf("wrap%0d_best_fcw", k), 32'(best_fcw2), 32'd40);
            chk($sformatf("wrap%0d_best_mag", k), 32'(best_mag2), k == 0 ? 32'd1024 : 32'd252);
            chk($sformatf("wrap%0d_fcw", k), 32'(fcw2), k == 0 ? 32'd40 : 32'd8184);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
